// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: parity modes, FSM encoding and
// a helper that gives the frame length in clock cycles.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } state_t;

    function automatic int frame_cycles(input int data_bits, input int parity,
                                        input int stop_bits, input int clks_per_bit);
        return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the head word, shown
// combinationally so a pop consumes exactly what was presented.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             wr, rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmitter: queued words are serialised LSB first with optional parity
// and one or two stop bits; frames run back to back while the FIFO has data.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_BITS-1:0]   i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_overflow,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_tx_data
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n, rdata;
    logic                 par, par_n, tx_n;
    logic                 full, empty, pop, load, bit_end;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_valid),
        .wdata (i_data),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (o_count)
    );

    assign o_ready = !full;
    assign o_busy  = (state != ST_IDLE);
    assign bit_end = (cnt == CNT_MAX);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = idx;
        sh_n         = sh;
        par_n        = par;
        tx_n         = o_tx_data;
        load         = 1'b0;
        pop          = 1'b0;
        o_frame_done = 1'b0;
        if (state != ST_IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;
        case (state)
            ST_IDLE: if (!empty) load = 1'b1;
            ST_START: if (bit_end) begin
                tx_n    = sh[0];
                sh_n    = sh >> 1;
                idx_n   = '0;
                state_n = ST_DATA;
            end
            ST_DATA: if (bit_end) begin
                if (idx == LAST_BIT) begin
                    idx_n = '0;
                    if (PARITY != PARITY_NONE) begin
                        tx_n    = par;
                        state_n = ST_PARITY;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = ST_STOP;
                    end
                end else begin
                    idx_n = idx + 4'd1;
                    tx_n  = sh[0];
                    sh_n  = sh >> 1;
                end
            end
            ST_PARITY: if (bit_end) begin
                tx_n    = 1'b1;
                idx_n   = '0;
                state_n = ST_STOP;
            end
            ST_STOP: if (bit_end) begin
                if (idx == LAST_STOP) begin
                    o_frame_done = 1'b1;
                    if (!empty) load = 1'b1;
                    else        state_n = ST_IDLE;
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Popping straight from the last stop cycle gives gap-free frames.
        if (load) begin
            pop     = 1'b1;
            sh_n    = rdata;
            par_n   = (^rdata) ^ (PARITY == PARITY_ODD);
            tx_n    = 1'b0;
            cnt_n   = '0;
            state_n = ST_START;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            par        <= 1'b0;
            o_tx_data  <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sh         <= sh_n;
            par        <= par_n;
            o_tx_data  <= tx_n;
            o_overflow <= i_valid && full;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: four instances cover no/even/odd parity,
// a shallow FIFO and a 7-bit two-stop-bit frame, all at 4 clocks per bit.
module tb_uart_frame_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0] d3 = '0;
    logic [3:0] v = '0;
    logic [3:0] rdy, ovf, busy, done, tx;
    logic [2:0] cnt0;
    logic [4:0] cnt1, cnt2, cnt3;

    int tests = 0, fails = 0;

    uart_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .i_data(d0), .i_valid(v[0]), .o_ready(rdy[0]), .o_overflow(ovf[0]),
        .o_count(cnt0), .o_busy(busy[0]), .o_frame_done(done[0]), .o_tx_data(tx[0]));
    uart_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .i_data(d1), .i_valid(v[1]), .o_ready(rdy[1]), .o_overflow(ovf[1]),
        .o_count(cnt1), .o_busy(busy[1]), .o_frame_done(done[1]), .o_tx_data(tx[1]));
    uart_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .i_data(d2), .i_valid(v[2]), .o_ready(rdy[2]), .o_overflow(ovf[2]),
        .o_count(cnt2), .o_busy(busy[2]), .o_frame_done(done[2]), .o_tx_data(tx[2]));
    uart_frame_tx #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2), .DEPTH(16)) u3 (
        .clk(clk), .rst(rst), .i_data(d3), .i_valid(v[3]), .o_ready(rdy[3]), .o_overflow(ovf[3]),
        .o_count(cnt3), .o_busy(busy[3]), .o_frame_done(done[3]), .o_tx_data(tx[3]));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-level pattern (first bit in bit 0) stretched to 4 cycles per bit; idle high after.
    function automatic logic [255:0] expand(input logic [31:0] bits, input int nb);
        logic [255:0] r;
        r = '1;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < 4; c++) r[b*4+c] = bits[b];
        return r;
    endfunction

    // Waits (bounded) for the line of instance s to go low, then records n cycles.
    task automatic capture(input int s, input int n, output logic [255:0] line, output int nd,
                           output int fd, output int ld, output int wt, output logic b0);
        line = '1; nd = 0; fd = -1; ld = -1; wt = 0; b0 = 1'b0;
        @(negedge clk);
        while (tx[s] !== 1'b0 && wt < 20) begin
            wt++;
            @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            line[i] = tx[s];
            if (i == 0) b0 = busy[s];
            if (done[s] === 1'b1) begin
                nd++;
                if (fd < 0) fd = i;
                ld = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic push(input int s, input logic [7:0] val);
        @(posedge clk); #1;
        case (s)
            0: d0 = val;
            1: d1 = val;
            2: d2 = val;
            default: d3 = val[6:0];
        endcase
        v[s] = 1'b1;
        @(posedge clk); #1;
        v[s] = 1'b0;
    endtask

    logic [255:0] line, exp4;
    int nd, fd, ld, wt, lows, busy_hi;
    logic b0;
    logic [9:0] fr;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 4'hF);
        chk("rst_busy", busy, 4'h0);
        chk("rst_done", done, 4'h0);
        chk("rst_ovf", ovf, 4'h0);
        chk("rst_ready", rdy, 4'hF);
        chk("rst_count", {cnt0, cnt1, cnt2, cnt3}, '0);

        // 1: plain 8N1 frame of 0x01
        push(0, 8'h01);
        capture(0, 44, line, nd, fd, ld, wt, b0);
        chk("t1_latency", wt, 1);
        chk("t1_line", line, expand(32'b1000000010, 10));
        chk("t1_done_cnt", nd, 1);
        chk("t1_done_pos", ld, 39);
        chk("t1_busy_in", b0, 1'b1);
        chk("t1_busy_end", busy[0], 1'b0);

        // 2: even parity of 0x01 and odd parity of 0x03 are both 1
        push(1, 8'h01);
        capture(1, 48, line, nd, fd, ld, wt, b0);
        chk("t2_even_line", line, expand(32'b11000000010, 11));
        chk("t2_even_done", ld, 43);
        push(2, 8'h03);
        capture(2, 48, line, nd, fd, ld, wt, b0);
        chk("t2_odd_line", line, expand(32'b11000000110, 11));
        chk("t2_odd_done", ld, 43);
        chk("t2_odd_busy", busy[2], 1'b0);

        // 3: back-to-back 0xA5, 0x5A
        @(posedge clk); #1 d0 = 8'hA5; v[0] = 1'b1;
        @(posedge clk); #1 d0 = 8'h5A;
        @(posedge clk); #1 v[0] = 1'b0;
        capture(0, 84, line, nd, fd, ld, wt, b0);
        chk("t3_line", line, expand({10'b1010110100, 10'b1101001010}, 20));
        chk("t3_done_cnt", nd, 2);
        chk("t3_done_first", fd, 39);
        chk("t3_done_last", ld, 79);

        // 4: overflow on a depth-4 FIFO while transmitting 0x10..0x14
        exp4 = '1;
        for (int f = 0; f < 5; f++) begin
            fr = {1'b1, 8'(8'h10 + f), 1'b0};
            for (int b = 0; b < 10; b++)
                for (int c = 0; c < 4; c++) exp4[f*40 + b*4 + c] = fr[b];
        end
        fork
            capture(0, 204, line, nd, fd, ld, wt, b0);
            begin
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk); #1 d0 = 8'(8'h10 + k); v[0] = 1'b1;
                    @(negedge clk);
                    chk($sformatf("t4_ready_%0d", k), rdy[0], (k < 5) ? 1'b1 : 1'b0);
                    if (k == 5) chk("t4_count_full", cnt0, 3'd4);
                end
                @(posedge clk); #1 v[0] = 1'b0;
                @(negedge clk);
                chk("t4_ovf_pulse", ovf[0], 1'b1);
                @(negedge clk);
                chk("t4_ovf_clear", ovf[0], 1'b0);
                chk("t4_count_after", cnt0, 3'd4);
            end
        join
        chk("t4_line", line, exp4);
        chk("t4_done_cnt", nd, 5);
        chk("t4_busy_end", busy[0], 1'b0);

        // 5: reset in the middle of a frame with three words queued
        @(posedge clk); #1 d0 = 8'h11; v[0] = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1 d0 = 8'(8'h11 + k);
        end
        @(posedge clk); #1 v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_count_pre", cnt0, 3'd3);
        chk("t5_busy_pre", busy[0], 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t5_tx_rst", tx[0], 1'b1);
        chk("t5_count_rst", cnt0, 3'd0);
        chk("t5_busy_rst", busy[0], 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        lows = 0; busy_hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) lows++;
            if (busy[0] !== 1'b0) busy_hi++;
        end
        chk("t5_line_quiet", lows, 0);
        chk("t5_busy_quiet", busy_hi, 0);

        // 6: 7 data bits, two stop bits, 0x7F
        push(3, 8'h7F);
        capture(3, 44, line, nd, fd, ld, wt, b0);
        chk("t6_line", line, expand(32'b1111111110, 10));
        chk("t6_done_pos", ld, 39);
        chk("t6_done_cnt", nd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Parametrised UART transmitter with an input byte FIFO. It serialises queued words onto a single line, with configurable data width, parity, stop bits and bit period.
- Used in two places: as the host-side stimulus driver for Top_level benches, and as the next-generation TX path feeding o_tx_data.
- It supports back-to-back frames, parity and overflow reporting. The hand-timed single-byte drive has none of these.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- CLKS_PER_BIT, 5208, clock cycles per bit period (≥2).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2).
- DEPTH, 16, FIFO depth in words (power of two, ≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_data  in  DATA_BITS  word to enqueue
- i_valid  in  1  push request
- o_ready  out  1  FIFO not full; a push is accepted when i_valid && o_ready
- o_overflow  out  1  one-cycle pulse when i_valid is asserted while full
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy
- o_busy  out  1  FSM not in IDLE
- o_frame_done  out  1  one-cycle pulse at the end of the last stop bit
- o_tx_data  out  1  serial line, idle high, registered

Behaviour:

Reset and general rules:
- One clock domain. Reset is asynchronous and active-low on rst.
- Reset values: o_tx_data=1, o_busy=0, o_frame_done=0, o_overflow=0, o_count=0, o_ready=1, FSM=IDLE, FIFO emptied.
- Reset asserted mid-frame forces the line high immediately. The partial frame and all queued words are discarded.

FIFO:
- Push is written at the clock edge where i_valid && o_ready.
- A push while full is dropped and pulses o_overflow. It has no other effect.
- Push and pop in the same cycle: o_count is unchanged. This is legal when full, but o_ready is evaluated before the pop, so a push while full is still rejected.
- Read and write pointers wrap modulo DEPTH.

FSM states: IDLE, START, DATA, PARITY, STOP.
- A bit counter counts 0..CLKS_PER_BIT-1. Every bit holds the line for exactly CLKS_PER_BIT cycles.
- IDLE: on an edge with FIFO non-empty, pop into the shift register, compute parity, drive o_tx_data=0, go to START.
- START → DATA: data is sent LSB first, DATA_BITS bits.
- DATA → PARITY if PARITY≠0, else → STOP.
- PARITY bit value:
  - even: XOR of the data bits
  - odd: the inverse of that XOR
- STOP: line held high for STOP_BITS×CLKS_PER_BIT cycles. On the final cycle, pulse o_frame_done.
  - If the FIFO is non-empty: pop and go straight to START, with zero idle cycles between frames.
  - Otherwise: go to IDLE.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.

Latency:
- A push at edge N makes the FIFO non-empty after edge N.
- The pop happens at edge N+1, and the line falls after edge N+1.
- Words are transmitted in strict FIFO order. A word is not modified once popped.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants
  - the FSM state encoding localparams
  - a function for frame length in cycles
- Sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, count).
- The FSM and baud counter live in uart_frame_tx.

Test Plan (all cases use CLKS_PER_BIT=4 unless stated):
1. PARITY=0, STOP_BITS=1, push 0x01 → line: low 4 cycles, bit0 high 4, bits1–7 low 28, stop high 4. Total 40 cycles. o_frame_done pulses once, o_busy falls after it.
2. PARITY=1, push 0x01 → parity bit 1. PARITY=2, push 0x03 → parity bit 1. Frame length 44 cycles.
3. Push 0xA5 then 0x5A on consecutive cycles → 80 contiguous cycles with no idle-high gap between frames. Bit order is LSB first; o_frame_done pulses twice.
4. DEPTH=4, FSM idle, i_valid held 6 cycles with values 0x10..0x15:
   - pushes 1–5 accepted (the first is popped immediately)
   - the 6th push is rejected with o_ready=0 and a one o_overflow pulse
   - 0x10..0x14 are transmitted in order
5. Assert rst in the DATA state of frame 1 with 3 words queued → o_tx_data=1 immediately, o_count=0. After release, the line stays high and nothing is transmitted.
6. STOP_BITS=2, DATA_BITS=7, push 0x7F → stop high 8 cycles. Total (1+7+2)×4 = 40 cycles.
